mem_stage_ctrl: RTL and testbench

MEM-stage responder to the EX/MEM pipeline register. Takes MemRead/MemWrite, address and write data from EX/MEM and runs the access against a multi-cycle data memory over a req/ack handshake. Drives stall_o, which feeds the enable/hold input of the IF/ID, ID/EX, EX/MEM and MEM/WB registers (high = hold). Returns read data toward MEM/WB.

---
 rtl/mem_stage_pkg.sv | 25 ++
 rtl/mem_hs_port.sv | 82 ++++++++
 rtl/mem_stage_ctrl.sv | 126 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and sizing helpers for the MEM-stage controller.
// Macro WBUF_EN (top level) enables the one-entry posted write buffer.
package mem_stage_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_hs_port.sv
// Request/acknowledge engine toward the data memory with a cycle-bounded wait.
// One access at a time; start_i is ignored while a request is outstanding.
module mem_hs_port
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              mem_ack_i,
    output logic              done_o,
    output logic              ack_o,
    output logic              tmo_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);

    localparam int CW = clog2(TIMEOUT);

    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_cyc;

    assign last_cyc = (cnt_q == CW'(TIMEOUT - 1));
    assign ack_o    = req_q & mem_ack_i;
    assign tmo_o    = req_q & ~mem_ack_i & last_cyc;
    assign done_o   = ack_o | tmo_o;

    always_comb begin
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        if (!req_q) begin
            if (start_i) begin
                req_d   = 1'b1;
                we_d    = we_i;
                addr_d  = addr_i;
                wdata_d = wdata_i;
                cnt_d   = '0;
            end
        end else if (done_o) begin
            req_d = 1'b0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs EX/MEM loads/stores on a multi-cycle memory and holds the pipeline.
// Define WBUF_EN to post stores into a one-entry buffer drained in the background.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] Addr_i,
    input  logic [DATA_W-1:0] Wdata_i,
    output logic              stall_o,
    output logic [DATA_W-1:0] Rdata_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    state_e            state_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              acc;
    logic              fsm_go;
    logic              hs_start, hs_we, hs_done, hs_ack, hs_tmo;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_wdata;
    logic              hold;

    assign acc = MemRead_i | MemWrite_i;

`ifdef WBUF_EN
    logic              wb_vld_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              post_wr;
    logic              drain_go;

    // The buffer only fills from IDLE and the FSM only leaves IDLE with it empty,
    // so a drain and a main-path access can never contend for the port.
    assign post_wr  = (state_q == ST_IDLE) & MemWrite_i & ~wb_vld_q;
    assign fsm_go   = (state_q == ST_IDLE) & MemRead_i & ~MemWrite_i & ~wb_vld_q;
    assign drain_go = wb_vld_q & ~mem_req_o;
    assign hs_start = fsm_go | drain_go;
    assign hs_we    = drain_go;
    assign hs_addr  = drain_go ? wb_addr_q : Addr_i;
    assign hs_wdata = drain_go ? wb_data_q : Wdata_i;
    assign hold     = ((state_q == ST_IDLE) & acc & ~post_wr) | (state_q == ST_BUSY);

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            wb_vld_q  <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (post_wr) begin
            wb_vld_q  <= 1'b1;
            wb_addr_q <= Addr_i;
            wb_data_q <= Wdata_i;
        end else if (wb_vld_q && hs_done) begin
            wb_vld_q  <= 1'b0;
        end
    end
`else
    assign fsm_go   = (state_q == ST_IDLE) & acc;
    assign hs_start = fsm_go;
    assign hs_we    = MemWrite_i;
    assign hs_addr  = Addr_i;
    assign hs_wdata = Wdata_i;
    assign hold     = fsm_go | (state_q == ST_BUSY);
`endif

    mem_hs_port #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_hs (
        .clk_i       (clk_i),
        .rst_ni      (start_i),
        .start_i     (hs_start),
        .we_i        (hs_we),
        .addr_i      (hs_addr),
        .wdata_i     (hs_wdata),
        .mem_ack_i   (mem_ack_i),
        .done_o      (hs_done),
        .ack_o       (hs_ack),
        .tmo_o       (hs_tmo),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o)
    );

    // Any timed-out access, main path or drain, latches the error.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (hs_tmo) err_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (fsm_go) state_q <= ST_BUSY;
                ST_BUSY: begin
                    if (hs_done) begin
                        if (hs_ack && !mem_we_o) rdata_q <= mem_rdata_i;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall_o = start_i & hold;
    assign Rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl with TIMEOUT=8: directed cases plus randomized accesses.
// Expected stall lengths, request counts, read data and error flag come from a transaction-level model.
module tb_mem_stage_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          start_i = 1'b0;
    logic          MemRead_i = 1'b0;
    logic          MemWrite_i = 1'b0;
    logic [AW-1:0] Addr_i = '0;
    logic [DW-1:0] Wdata_i = '0;
    logic          stall_o;
    logic [DW-1:0] Rdata_o;
    logic          err_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;

    always #5 clk_i = ~clk_i;

    mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i       (clk_i),
        .start_i     (start_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .Wdata_i     (Wdata_i),
        .stall_o     (stall_o),
        .Rdata_o     (Rdata_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [DW-1:0] m_rdata;
    logic          m_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction, answers the memory after ack_at BUSY cycles (0 or >TO: never),
    // runs until stall drops (the DONE cycle, or at once for a bubble), then checks against the model.
    task automatic do_txn(input string tag, input logic rd, input logic wr,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int ack_at, input logic [DW-1:0] rdata, input logic spur);
        int            stalls, busy, exp_stall, exp_busy;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic          s_we, stable, done, req_done, acc, acked;
        stalls = 0; busy = 0; stable = 1'b1; done = 1'b0; req_done = 1'b0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        MemRead_i = rd; MemWrite_i = wr; Addr_i = addr; Wdata_i = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk_i);
            if (stall_o) begin
                stalls++;
                if (mem_req_o) begin
                    if (busy == 0) begin
                        s_addr = mem_addr_o; s_we = mem_we_o; s_wdata = mem_wdata_o;
                    end else if (mem_addr_o !== s_addr || mem_we_o !== s_we || mem_wdata_o !== s_wdata) begin
                        stable = 1'b0;
                    end
                    busy++;
                    if (busy == ack_at) begin
                        mem_ack_i = 1'b1; mem_rdata_i = rdata;
                    end
                end
                @(posedge clk_i); #1;
                mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            end else begin
                done = 1'b1;
                req_done = mem_req_o;
                MemRead_i = 1'b0; MemWrite_i = 1'b0;
                if (spur) begin
                    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
                end
            end
        end
        check({tag, "_finished"}, done, 1'b1);

        acc       = rd | wr;
        acked     = acc && ack_at >= 1 && ack_at <= TO;
        exp_busy  = !acc ? 0 : (acked ? ack_at : TO);
        exp_stall = !acc ? 0 : exp_busy + 1;
        if (acc && !wr && acked) m_rdata = rdata;
        if (acc && !acked) m_err = 1'b1;

        check({tag, "_stall_cycles"}, stalls, exp_stall);
        check({tag, "_busy_cycles"}, busy, exp_busy);
        check({tag, "_req_in_done"}, req_done, 1'b0);
        if (acc) begin
            check({tag, "_addr"}, s_addr, addr);
            check({tag, "_we"}, s_we, wr);
            check({tag, "_stable"}, stable, 1'b1);
            if (wr) check({tag, "_wdata"}, s_wdata, wdata);
        end
        check({tag, "_rdata"}, Rdata_o, m_rdata);
        check({tag, "_err"}, err_o, m_err);
    endtask

    initial begin
        logic          got_req;
        int            op;
        m_rdata = '0;
        m_err   = 1'b0;

        // Reset held with a load pending: everything quiet, including stall.
        MemRead_i = 1'b1; Addr_i = 32'h40;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", stall_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_wdata", mem_wdata_o, 32'h0);
        check("rst_rdata", Rdata_o, 32'h0);
        check("rst_err", err_o, 1'b0);
        MemRead_i = 1'b0; Addr_i = '0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_stall", stall_o, 1'b0);
        check("post_rst_req", mem_req_o, 1'b0);

        do_txn("load40", 1'b1, 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
`ifndef WBUF_EN
        do_txn("store80", 1'b0, 1'b1, 32'h80, 32'h1234_5678, 1, 32'h9999_9999, 1'b0);
        do_txn("both_is_write", 1'b1, 1'b1, 32'h84, 32'hCAFE_F00D, 2, 32'h5555_5555, 1'b0);
`endif
        do_txn("timeout", 1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b0);
        do_txn("load_after_to", 1'b1, 1'b0, 32'h104, 32'h0, 2, 32'h0BAD_F00D, 1'b0);

        // Ack with no request outstanding must be ignored.
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
        @(negedge clk_i);
        check("idle_ack_stall", stall_o, 1'b0);
        check("idle_ack_req", mem_req_o, 1'b0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        check("idle_ack_rdata", Rdata_o, m_rdata);

`ifndef WBUF_EN
        do_txn("b2b_load", 1'b1, 1'b0, 32'h10, 32'h0, 1, 32'h1111_2222, 1'b1);
        do_txn("b2b_store", 1'b0, 1'b1, 32'h14, 32'h3333_4444, 2, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 3);
            do_txn($sformatf("rnd%0d", i), (op == 1 || op == 3), (op >= 2),
                   $urandom, $urandom, $urandom_range(1, 10), $urandom, 1'($urandom_range(0, 1)));
        end
`else
        begin
            logic          wr_acked, rd_seen, rd_after_wr, wb_done;
            logic [AW-1:0] w_addr, r_addr;
            logic [DW-1:0] w_data;
            wr_acked = 1'b0; rd_seen = 1'b0; rd_after_wr = 1'b0; wb_done = 1'b0;
            w_addr = '0; r_addr = '0; w_data = '0;
            @(posedge clk_i); #1;
            MemWrite_i = 1'b1; Addr_i = 32'h20; Wdata_i = 32'hA5A5_5A5A;
            @(negedge clk_i);
            check("wb_store_stall", stall_o, 1'b0);
            @(posedge clk_i); #1;
            MemWrite_i = 1'b0; MemRead_i = 1'b1;
            @(negedge clk_i);
            check("wb_load_held", stall_o, 1'b1);
            for (int c = 0; c < 40 && !wb_done; c++) begin
                if (!stall_o) begin
                    wb_done = 1'b1;
                end else begin
                    if (mem_req_o && mem_we_o && !wr_acked) begin
                        w_addr = mem_addr_o; w_data = mem_wdata_o;
                        mem_ack_i = 1'b1; wr_acked = 1'b1;
                    end else if (mem_req_o && !mem_we_o && !rd_seen) begin
                        r_addr = mem_addr_o; rd_after_wr = wr_acked; rd_seen = 1'b1;
                        mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_0020;
                    end
                    @(posedge clk_i); #1;
                    mem_ack_i = 1'b0;
                    @(negedge clk_i);
                end
            end
            MemRead_i = 1'b0;
            check("wb_finished", wb_done, 1'b1);
            check("wb_drain_addr", w_addr, 32'h20);
            check("wb_drain_data", w_data, 32'hA5A5_5A5A);
            check("wb_read_seen", rd_seen, 1'b1);
            check("wb_read_addr", r_addr, 32'h20);
            check("wb_read_after_write", rd_after_wr, 1'b1);
            check("wb_rdata", Rdata_o, 32'h7777_0020);
            m_rdata = 32'h7777_0020;
        end
`endif

        // Reset dropped mid-access clears the port immediately, with no clock edge.
        @(posedge clk_i); #1;
        MemRead_i = 1'b1; Addr_i = 32'h44;
        got_req = 1'b0;
        for (int c = 0; c < 5 && !got_req; c++) begin
            @(negedge clk_i);
            got_req = mem_req_o;
        end
        check("midrst_req_before", got_req, 1'b1);
        #2;
        start_i = 1'b0;
        #1;
        check("midrst_req", mem_req_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        check("midrst_addr", mem_addr_o, 32'h0);
        check("midrst_rdata", Rdata_o, 32'h0);
        check("midrst_err", err_o, 1'b0);
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        m_rdata = '0;
        m_err   = 1'b0;
        @(negedge clk_i);
        check("midrst_idle_stall", stall_o, 1'b0);
        check("midrst_idle_req", mem_req_o, 1'b0);
        do_txn("load_after_rst", 1'b1, 1'b0, 32'h48, 32'h0, 1, 32'h0600_D00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
